// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared state type and bit-timing constants for the USB full-speed transmit path
package usb_tx_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, EOP_SE0, EOP_J} tx_timer_state_t;
  localparam int CLKS_PER_BIT_FS = 8;
  localparam int EOP_SE0_BITS = 2;
  localparam int EOP_J_BITS = 1;
endpackage

// File: rtl/tx_period_counter.sv
// tx_period_counter: 4-bit wrapping counter with clear, enable and rollover flag
module tx_period_counter (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] roll_val,
  output logic [3:0] count,
  output logic       rollover
);
  assign rollover = en && count == roll_val;
  always_ff @(posedge clk)
    if (!n_rst || clr) count <= '0;
    else if (en) count <= rollover ? 4'd0 : count + 4'd1;
endmodule

// File: rtl/tx_timer.sv
// tx_timer: full-speed bit timer driving the TX shift register, bit stuffing and EOP sequencing
module tx_timer
  import usb_tx_pkg::tx_timer_state_t, usb_tx_pkg::IDLE, usb_tx_pkg::ACTIVE, usb_tx_pkg::EOP_SE0, usb_tx_pkg::EOP_J;
#(
  parameter int CLKS_PER_BIT = usb_tx_pkg::CLKS_PER_BIT_FS,
  parameter int EOP_SE0_BITS = usb_tx_pkg::EOP_SE0_BITS,
  parameter int EOP_J_BITS   = usb_tx_pkg::EOP_J_BITS
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       timer_en,
  input  logic       timer_clr,
  input  logic       stuff_req,
  input  logic       last_byte,
  output logic       bit_strobe,
  output logic       shift_strobe,
  output logic       byte_done,
  output logic       stuff_active,
  output logic       eop_se0,
  output logic       eop_j,
  output logic       eop_done,
  output logic       tx_busy,
  output logic [3:0] pd_count,
  output logic [3:0] bit_count
);
  tx_timer_state_t state, state_n;
  logic [3:0] bit_n, eop_cnt, eop_n;
  logic stuff, stuff_n, eop_pending, pend_n;
  logic advance, rollover, boundary;
  assign advance = (state == ACTIVE && timer_en) || state == EOP_SE0 || state == EOP_J;
  tx_period_counter u_pd (
    .clk(clk), .n_rst(n_rst), .clr(state == IDLE || timer_clr), .en(advance),
    .roll_val(4'(CLKS_PER_BIT - 1)), .count(pd_count), .rollover(rollover)
  );
  // an aborting cycle must not leak strobes to the shift register or controller
  assign boundary     = n_rst && !timer_clr && rollover;
  assign bit_strobe   = boundary;
  assign shift_strobe = boundary && state == ACTIVE && !stuff;
  assign byte_done    = shift_strobe && bit_count == 4'd7;
  assign stuff_active = stuff;
  assign eop_se0      = state == EOP_SE0;
  assign eop_j        = state == EOP_J;
  assign eop_done     = boundary && state == EOP_J && eop_cnt == 4'(EOP_J_BITS - 1);
  assign tx_busy      = state != IDLE;
  always_comb begin
    state_n = state;
    bit_n   = bit_count;
    eop_n   = eop_cnt;
    stuff_n = stuff;
    pend_n  = eop_pending;
    case (state)
      IDLE: state_n = timer_en ? ACTIVE : IDLE;
      ACTIVE:
        if (boundary) begin
          stuff_n = stuff_req;
          bit_n   = stuff ? bit_count : bit_count == 4'd7 ? 4'd0 : bit_count + 4'd1;
          if (eop_pending) begin
            state_n = EOP_SE0;
            stuff_n = 1'b0;
            pend_n  = 1'b0;
          end else if (byte_done && last_byte) begin
            pend_n  = stuff_req;
            state_n = stuff_req ? ACTIVE : EOP_SE0;
          end
        end
      EOP_SE0:
        if (boundary) begin
          eop_n   = eop_cnt == 4'(EOP_SE0_BITS - 1) ? 4'd0 : eop_cnt + 4'd1;
          state_n = eop_cnt == 4'(EOP_SE0_BITS - 1) ? EOP_J : EOP_SE0;
        end
      default:
        if (boundary) begin
          eop_n   = eop_cnt == 4'(EOP_J_BITS - 1) ? 4'd0 : eop_cnt + 4'd1;
          state_n = eop_cnt == 4'(EOP_J_BITS - 1) ? IDLE : EOP_J;
        end
    endcase
  end
  always_ff @(posedge clk)
    if (!n_rst || timer_clr) begin
      state       <= IDLE;
      bit_count   <= '0;
      eop_cnt     <= '0;
      stuff       <= 1'b0;
      eop_pending <= 1'b0;
    end else begin
      state       <= state_n;
      bit_count   <= bit_n;
      eop_cnt     <= eop_n;
      stuff       <= stuff_n;
      eop_pending <= pend_n;
    end
endmodule

// File: doc/tx_timer.md
Name: tx_timer

Overview:
Bit-timing generator for the USB 1.0 transmit path, counterpart of the receiver's bit timer. It divides the system clock into full-speed bit periods and tells the transmit shift register when to advance. It inserts bit-stuff periods on request from the bit-stuffer and sequences the End-of-Packet (EOP) as two SE0 bit times followed by one J bit time. It sits between the TX controller FSM and the shift register / NRZI encoder.

Parameters:
CLKS_PER_BIT, 8, clock cycles per bit period (96 MHz clk / 12 Mbps); legal range 2..16.
EOP_SE0_BITS, 2, number of bit periods SE0 is driven during EOP.
EOP_J_BITS, 1, number of bit periods J is driven after SE0.

Ports:
clk  in  1  system clock, rising edge.
n_rst  in  1  reset; synchronous, active-low.
timer_en  in  1  start from IDLE; while ACTIVE, 0 freezes the counters.
timer_clr  in  1  synchronous abort to IDLE.
stuff_req  in  1  from the bit-stuffer; sampled at a bit boundary. 1 means the next period is a stuff bit.
last_byte  in  1  from the TX controller; sampled with byte_done. 1 means the byte just finished is the final byte.
bit_strobe  out  1  one-cycle pulse at the end of every bit period, including stuff and EOP periods.
shift_strobe  out  1  one-cycle pulse at the end of a data bit period only.
byte_done  out  1  one-cycle pulse at the end of the 8th data bit; the controller loads the next byte on this pulse.
stuff_active  out  1  high for the whole of a stuff period.
eop_se0  out  1  high while SE0 is driven.
eop_j  out  1  high while EOP J is driven.
eop_done  out  1  one-cycle pulse when the EOP completes.
tx_busy  out  1  high whenever state != IDLE.
pd_count  out  4  cycle index within the current bit period.
bit_count  out  4  data bits completed in the current byte, 0..7.

Behaviour:
- Reset (n_rst=0 at a rising edge): state IDLE; pd_count, bit_count and eop bit counter = 0; stuff flag and eop_pending = 0; all outputs 0.
- Priority: n_rst > timer_clr > normal operation.
- timer_clr=1: IDLE on the next cycle, with the same values as reset. No strobes or eop_done are emitted for that cycle.
- States: IDLE, ACTIVE, EOP_SE0, EOP_J.
- IDLE: counters held at 0. timer_en=1 → ACTIVE on the next cycle with pd_count=0 and bit_count=0.
- Boundary cycle: pd_count == CLKS_PER_BIT-1 in a non-IDLE state with the counters advancing.
  - All strobes are combinational decodes of registered state in the boundary cycle.
  - pd_count wraps to 0 on the next edge.
- ACTIVE with timer_en=0: pd_count, bit_count and the stuff flag are held; no strobes. EOP states ignore timer_en.
- ACTIVE, data period boundary: bit_strobe=1 and shift_strobe=1. bit_count increments; at 7 it wraps to 0 and byte_done=1.
- ACTIVE, stuff period boundary: bit_strobe=1, shift_strobe=0, byte_done=0, bit_count held.
- Stuff flag: at every ACTIVE boundary it is loaded with stuff_req. stuff_active equals the flag. Back-to-back stuff periods are honoured.
- byte_done with last_byte=1:
  - If stuff_req=0 → EOP_SE0.
  - If stuff_req=1 → set eop_pending and run one stuff period. At the end of that period go to EOP_SE0, ignoring stuff_req.
- EOP_SE0: eop_se0=1 for EOP_SE0_BITS full periods, with bit_strobe at each boundary. Then → EOP_J.
- EOP_J: eop_j=1 for EOP_J_BITS periods. At its final boundary eop_done=1 and the state goes to IDLE on the next cycle.
- byte_done with last_byte=0: stays ACTIVE; the next byte starts immediately with no idle cycle.
- Reset or timer_clr mid-byte or mid-EOP: abort with no completion pulses.
- Width rule: pd_count compares against CLKS_PER_BIT-1 using 4-bit unsigned arithmetic.

Decomposition:
- Shared package usb_tx_pkg holds:
  - tx_timer_state_t enum {IDLE, ACTIVE, EOP_SE0, EOP_J};
  - localparams CLKS_PER_BIT_FS=8, EOP_SE0_BITS=2, EOP_J_BITS=1.
- One sub-module, tx_period_counter: a 4-bit wrapping counter with clear, enable and rollover value, and a rollover flag output. It is instantiated for pd_count.
- bit_count and the EOP bit counter stay inline.

Test Plan:
(All with CLKS_PER_BIT=8; times are cycles after ACTIVE is entered.)
- Single byte, last_byte=1, no stuff:
  - shift_strobe at 7, 15, …, 63; byte_done at 63 only;
  - eop_se0 high for 64–79, eop_j for 80–87, eop_done at 87; tx_busy low at 88.
- stuff_req=1 at the boundary ending bit 6 (cycle 47):
  - stuff_active high for 48–55, with bit_strobe at 55 and no shift_strobe;
  - bit_count holds 6 during that period; byte_done moves to 71.
- Two bytes with last_byte 0 then 1: byte_done at 63 and 127; bit_count wraps 7→0 at 64; eop_done at 151.
- timer_en low for 20 cycles starting at cycle 10: pd_count and bit_count frozen (pd_count=2, bit_count=1); byte_done at 83.
- stuff_req=1 with byte_done and last_byte=1 at 63: stuff period 64–71 with no shift_strobe; eop_se0 starts at 72.
- timer_clr at cycle 70 (during EOP_SE0): eop_se0=0 and tx_busy=0 from 71, no eop_done. Repeat with n_rst=0 at cycle 30 → all outputs 0 on the next cycle.
